pipeline_hazard_ctrl: RTL and testbench

Hazard/sequencing controller for the 5-stage MIPS pipeline. Sits beside the ID stage, watches IF/ID, ID/EX and EX/MEM register fields, and drives PC/IF-ID write enables, the ID/EX bubble and the IF/ID flush. It covers load-use stalls, stalls for branches resolved in ID, and multi-cycle taken-branch flushes. It keeps saturating stall and flush counters for performance debug.

---
 rtl/pipeline_hazard_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//
// Hazard and sequencing controller for a 5-stage MIPS pipeline. It sits beside the
// ID stage and detects three cases:
//   - load-use hazards
//   - hazards on branches that compare in ID
//   - multi-cycle taken-branch flushes
// It drives the PC and IF/ID write enables, the ID/EX bubble and the IF/ID flush.
// It also keeps saturating stall and flush counters for performance debug.
//
// Parameters:
//   BRANCH_PENALTY  IF/ID flush cycles per taken branch (1..7)
//   CNT_W           width of StallCount / FlushCount
//
// Ports:
//   Clk, Reset      clock; synchronous active-high reset
//   IFIDrs/rt       source fields of the instruction in ID
//   IFIDUsesRt      ID instruction reads rt
//   IDBranch        ID instruction is beq/bne
//   PCSrc           branch taken, resolved in ID this cycle
//   IDEX*           EX-stage load / regwrite / destination
//   EXMEM*          MEM-stage load / destination
//   PCWrite         PC may update
//   IFIDWrite       IF/ID may load
//   IDEXBubble      zero the ID/EX control lines
//   IFIDFlush       replace the IF/ID instruction with a nop
//   State           0 RUN, 1 STALL, 2 FLUSH
//   StallCount      saturating count of bubble cycles
//   FlushCount      saturating count of flush cycles
module pipeline_hazard_ctrl #(
    parameter int unsigned BRANCH_PENALTY = 1,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [4:0]       IFIDrs,
    input  logic [4:0]       IFIDrt,
    input  logic             IFIDUsesRt,
    input  logic             IDBranch,
    input  logic             PCSrc,
    input  logic             IDEXMemRead,
    input  logic             IDEXRegWrite,
    input  logic [4:0]       IDEXWriteReg,
    input  logic             EXMEMMemRead,
    input  logic [4:0]       EXMEMWriteReg,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IDEXBubble,
    output logic             IFIDFlush,
    output logic [1:0]       State,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StStall = 2'd1,
        StFlush = 2'd2,
        StBad   = 2'd3
    } state_e;

    localparam logic [2:0]       FlushInit = 3'(BRANCH_PENALTY - 1);
    localparam logic [CNT_W-1:0] CntMax    = '1;

    state_e           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    // Register 0 is hardwired to zero, so it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] r, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic uses_rt);
        return (r != 5'd0) && ((r == rs) || (uses_rt && (r == rt)));
    endfunction

    logic match_ex, match_mem;
    logic need1, need2, need_any;

    always_comb begin
        match_ex  = reg_match(IDEXWriteReg, IFIDrs, IFIDrt, IFIDUsesRt);
        match_mem = reg_match(EXMEMWriteReg, IFIDrs, IFIDrt, IFIDUsesRt);
        // A branch that depends on a load in EX needs both the load to reach MEM
        // and the loaded value to come back before ID can compare: two bubbles.
        need2 = IDBranch && IDEXMemRead && match_ex;
        need1 = (IDEXMemRead && match_ex) ||
                (IDBranch && IDEXRegWrite && match_ex) ||
                (IDBranch && EXMEMMemRead && match_mem);
        need_any = need1 || need2;
    end

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StRun;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StStall, StFlush: begin
                if (cnt_q <= 3'd1) begin
                    state_d = StRun;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                // The remaining RUN cycle is the first bubble/flush, hence cnt = total - 1.
                if (need2) begin
                    state_d = StStall;
                    cnt_d   = 3'd1;
                end else if (!need_any && PCSrc && (BRANCH_PENALTY > 1)) begin
                    state_d = StFlush;
                    cnt_d   = FlushInit;
                end else begin
                    state_d = StRun;
                    cnt_d   = 3'd0;
                end
            end
        endcase
    end

    // Output logic: Mealy in RUN so a stall acts in the cycle it is detected.
    always_comb begin
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IDEXBubble = 1'b0;
        IFIDFlush  = 1'b0;
        if (Reset) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXBubble = 1'b1;
            IFIDFlush  = 1'b1;
        end else begin
            case (state_q)
                StStall: begin
                    PCWrite    = 1'b0;
                    IFIDWrite  = 1'b0;
                    IDEXBubble = 1'b1;
                end
                StFlush: begin
                    IFIDFlush = 1'b1;
                end
                default: begin
                    // Branch operands are stale while stalling, so PCSrc is ignored.
                    if (need_any) begin
                        PCWrite    = 1'b0;
                        IFIDWrite  = 1'b0;
                        IDEXBubble = 1'b1;
                    end else if (PCSrc) begin
                        IFIDFlush = 1'b1;
                    end
                end
            endcase
        end
    end

    // Performance counters; the forced outputs during reset are not counted.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (IDEXBubble && (stall_cnt_q != CntMax)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (IFIDFlush && (flush_cnt_q != CntMax)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign State      = state_q;
    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    localparam int unsigned Penalty = 3;
    localparam int unsigned CntW    = 3;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       br;
        logic       pcsrc;
        logic       ex_mr;
        logic       ex_rw;
        logic [4:0] ex_wr;
        logic       mem_mr;
        logic [4:0] mem_wr;
    } stim_t;

    typedef struct packed {
        logic            pcw;
        logic            ifw;
        logic            bub;
        logic            fl;
        logic [1:0]      st;
        logic [CntW-1:0] sc;
        logic [CntW-1:0] fc;
    } obs_t;

    logic            Clk;
    logic            Reset;
    logic [4:0]      IFIDrs, IFIDrt, IDEXWriteReg, EXMEMWriteReg;
    logic            IFIDUsesRt, IDBranch, PCSrc, IDEXMemRead, IDEXRegWrite, EXMEMMemRead;
    logic            PCWrite, IFIDWrite, IDEXBubble, IFIDFlush;
    logic [1:0]      State;
    logic [CntW-1:0] StallCount, FlushCount;
    obs_t            obs;

    int compared   = 0;
    int mismatched = 0;
    obs_t sb[$];

    pipeline_hazard_ctrl #(
        .BRANCH_PENALTY(Penalty),
        .CNT_W         (CntW)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .IFIDrs       (IFIDrs),
        .IFIDrt       (IFIDrt),
        .IFIDUsesRt   (IFIDUsesRt),
        .IDBranch     (IDBranch),
        .PCSrc        (PCSrc),
        .IDEXMemRead  (IDEXMemRead),
        .IDEXRegWrite (IDEXRegWrite),
        .IDEXWriteReg (IDEXWriteReg),
        .EXMEMMemRead (EXMEMMemRead),
        .EXMEMWriteReg(EXMEMWriteReg),
        .PCWrite      (PCWrite),
        .IFIDWrite    (IFIDWrite),
        .IDEXBubble   (IDEXBubble),
        .IFIDFlush    (IFIDFlush),
        .State        (State),
        .StallCount   (StallCount),
        .FlushCount   (FlushCount)
    );

    assign obs = {PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, State, StallCount, FlushCount};

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic stim_t mk_s(input int rs, input int rt, input int uses_rt, input int br,
                                   input int pcsrc, input int ex_mr, input int ex_rw,
                                   input int ex_wr, input int mem_mr, input int mem_wr);
        stim_t s;
        s.rs      = 5'(rs);
        s.rt      = 5'(rt);
        s.uses_rt = 1'(uses_rt);
        s.br      = 1'(br);
        s.pcsrc   = 1'(pcsrc);
        s.ex_mr   = 1'(ex_mr);
        s.ex_rw   = 1'(ex_rw);
        s.ex_wr   = 5'(ex_wr);
        s.mem_mr  = 1'(mem_mr);
        s.mem_wr  = 5'(mem_wr);
        return s;
    endfunction

    function automatic obs_t mk_e(input int pcw, input int ifw, input int bub, input int fl,
                                  input int st, input int sc, input int fc);
        obs_t e;
        e.pcw = 1'(pcw);
        e.ifw = 1'(ifw);
        e.bub = 1'(bub);
        e.fl  = 1'(fl);
        e.st  = 2'(st);
        e.sc  = CntW'(sc);
        e.fc  = CntW'(fc);
        return e;
    endfunction

    function automatic stim_t idle();
        return mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    // Apply one cycle of stimulus just after the edge and queue what it should produce.
    task automatic drive(input logic rst, input stim_t s, input obs_t e);
        @(posedge Clk);
        #1;
        Reset         = rst;
        IFIDrs        = s.rs;
        IFIDrt        = s.rt;
        IFIDUsesRt    = s.uses_rt;
        IDBranch      = s.br;
        PCSrc         = s.pcsrc;
        IDEXMemRead   = s.ex_mr;
        IDEXRegWrite  = s.ex_rw;
        IDEXWriteReg  = s.ex_wr;
        EXMEMMemRead  = s.mem_mr;
        EXMEMWriteReg = s.mem_wr;
        sb.push_back(e);
    endtask

    // One reset cycle, uncompared; the next compared cycle sees cleared state.
    task automatic do_reset();
        drive(1'b1, idle(), '0);
        void'(sb.pop_back());
    endtask

    task automatic test_reset();
        logic  rq[$];
        stim_t sq[$];
        obs_t  eq[$];
        obs_t  e;
        rq.push_back(1'b1); sq.push_back(idle()); eq.push_back(mk_e(0, 0, 1, 1, 0, 0, 0));
        rq.push_back(1'b0); sq.push_back(idle()); eq.push_back(mk_e(1, 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < sq.size(); i++) begin
            drive(rq[i], sq[i], eq[i]);
            @(negedge Clk);
            e = sb.pop_front();
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("FAIL reset[%0d]: got %b want %b (pcw ifw bub fl st sc fc)", i, obs, e);
            end
        end
    endtask

    task automatic test_load_use();
        stim_t sq[$];
        obs_t  eq[$];
        obs_t  e;
        do_reset();
        sq.push_back(mk_s(8, 0, 0, 0, 0, 1, 0, 8, 0, 0));  eq.push_back(mk_e(0, 0, 1, 0, 0, 0, 0));
        sq.push_back(idle());                              eq.push_back(mk_e(1, 1, 0, 0, 0, 1, 0));
        sq.push_back(mk_s(3, 12, 1, 0, 0, 1, 0, 12, 0, 0)); eq.push_back(mk_e(0, 0, 1, 0, 0, 1, 0));
        sq.push_back(idle());                              eq.push_back(mk_e(1, 1, 0, 0, 0, 2, 0));
        for (int i = 0; i < sq.size(); i++) begin
            drive(1'b0, sq[i], eq[i]);
            @(negedge Clk);
            e = sb.pop_front();
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("FAIL load_use[%0d]: got %b want %b (pcw ifw bub fl st sc fc)", i, obs, e);
            end
        end
    endtask

    task automatic test_no_hazard();
        stim_t sq[$];
        obs_t  eq[$];
        obs_t  e;
        do_reset();
        sq.push_back(mk_s(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));  // load to r0
        sq.push_back(mk_s(3, 9, 0, 0, 0, 1, 0, 9, 0, 0));  // rt not read
        sq.push_back(mk_s(0, 0, 0, 1, 0, 0, 0, 0, 1, 0));  // branch, MEM load to r0
        sq.push_back(mk_s(4, 0, 0, 0, 0, 0, 0, 0, 1, 4));  // MEM load, non-branch
        sq.push_back(mk_s(4, 0, 0, 0, 0, 0, 1, 4, 0, 0));  // EX ALU write, non-branch
        sq.push_back(mk_s(7, 6, 0, 1, 0, 0, 1, 6, 0, 0));  // branch, rt unused
        sq.push_back(idle());
        for (int i = 0; i < sq.size(); i++) eq.push_back(mk_e(1, 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < sq.size(); i++) begin
            drive(1'b0, sq[i], eq[i]);
            @(negedge Clk);
            e = sb.pop_front();
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("FAIL no_hazard[%0d]: got %b want %b (pcw ifw bub fl st sc fc)", i, obs, e);
            end
        end
    endtask

    task automatic test_branch_after_load();
        stim_t sq[$];
        obs_t  eq[$];
        obs_t  e;
        do_reset();
        sq.push_back(mk_s(1, 5, 1, 1, 1, 1, 0, 5, 0, 0)); eq.push_back(mk_e(0, 0, 1, 0, 0, 0, 0));
        sq.push_back(mk_s(1, 5, 1, 1, 1, 1, 0, 5, 0, 0)); eq.push_back(mk_e(0, 0, 1, 0, 1, 1, 0));
        sq.push_back(mk_s(1, 5, 1, 1, 0, 0, 0, 0, 0, 0)); eq.push_back(mk_e(1, 1, 0, 0, 0, 2, 0));
        sq.push_back(idle());                             eq.push_back(mk_e(1, 1, 0, 0, 0, 2, 0));
        for (int i = 0; i < sq.size(); i++) begin
            drive(1'b0, sq[i], eq[i]);
            @(negedge Clk);
            e = sb.pop_front();
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("FAIL branch_after_load[%0d]: got %b want %b (pcw ifw bub fl st sc fc)",
                         i, obs, e);
            end
        end
    endtask

    task automatic test_taken_branch();
        stim_t sq[$];
        obs_t  eq[$];
        obs_t  e;
        do_reset();
        sq.push_back(mk_s(0, 0, 0, 1, 1, 0, 0, 0, 0, 0)); eq.push_back(mk_e(1, 1, 0, 1, 0, 0, 0));
        // Hazard and PCSrc during FLUSH must be ignored.
        sq.push_back(mk_s(8, 0, 0, 1, 1, 1, 0, 8, 0, 0)); eq.push_back(mk_e(1, 1, 0, 1, 2, 0, 1));
        sq.push_back(idle());                             eq.push_back(mk_e(1, 1, 0, 1, 2, 0, 2));
        sq.push_back(idle());                             eq.push_back(mk_e(1, 1, 0, 0, 0, 0, 3));
        for (int i = 0; i < sq.size(); i++) begin
            drive(1'b0, sq[i], eq[i]);
            @(negedge Clk);
            e = sb.pop_front();
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("FAIL taken_branch[%0d]: got %b want %b (pcw ifw bub fl st sc fc)",
                         i, obs, e);
            end
        end
    endtask

    task automatic test_stall_then_branch();
        stim_t sq[$];
        obs_t  eq[$];
        obs_t  e;
        do_reset();
        sq.push_back(mk_s(7, 0, 0, 1, 1, 0, 1, 7, 0, 0)); eq.push_back(mk_e(0, 0, 1, 0, 0, 0, 0));
        sq.push_back(mk_s(7, 0, 0, 1, 1, 0, 0, 0, 1, 7)); eq.push_back(mk_e(0, 0, 1, 0, 0, 1, 0));
        sq.push_back(mk_s(7, 0, 0, 1, 1, 0, 0, 0, 0, 0)); eq.push_back(mk_e(1, 1, 0, 1, 0, 2, 0));
        sq.push_back(idle());                             eq.push_back(mk_e(1, 1, 0, 1, 2, 2, 1));
        sq.push_back(idle());                             eq.push_back(mk_e(1, 1, 0, 1, 2, 2, 2));
        sq.push_back(idle());                             eq.push_back(mk_e(1, 1, 0, 0, 0, 2, 3));
        for (int i = 0; i < sq.size(); i++) begin
            drive(1'b0, sq[i], eq[i]);
            @(negedge Clk);
            e = sb.pop_front();
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("FAIL stall_then_branch[%0d]: got %b want %b (pcw ifw bub fl st sc fc)",
                         i, obs, e);
            end
        end
    endtask

    task automatic test_reset_mid_seq();
        logic  rq[$];
        stim_t sq[$];
        obs_t  eq[$];
        obs_t  e;
        do_reset();
        rq.push_back(1'b0); sq.push_back(mk_s(1, 5, 1, 1, 0, 1, 0, 5, 0, 0));
        eq.push_back(mk_e(0, 0, 1, 0, 0, 0, 0));
        rq.push_back(1'b1); sq.push_back(idle()); eq.push_back(mk_e(0, 0, 1, 1, 1, 1, 0));
        rq.push_back(1'b0); sq.push_back(idle()); eq.push_back(mk_e(1, 1, 0, 0, 0, 0, 0));
        rq.push_back(1'b0); sq.push_back(mk_s(0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        eq.push_back(mk_e(1, 1, 0, 1, 0, 0, 0));
        rq.push_back(1'b1); sq.push_back(idle()); eq.push_back(mk_e(0, 0, 1, 1, 2, 0, 1));
        rq.push_back(1'b0); sq.push_back(idle()); eq.push_back(mk_e(1, 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < sq.size(); i++) begin
            drive(rq[i], sq[i], eq[i]);
            @(negedge Clk);
            e = sb.pop_front();
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("FAIL reset_mid_seq[%0d]: got %b want %b (pcw ifw bub fl st sc fc)",
                         i, obs, e);
            end
        end
    endtask

    task automatic test_saturation();
        stim_t sq[$];
        obs_t  eq[$];
        obs_t  e;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            sq.push_back(mk_s(8, 0, 0, 0, 0, 1, 0, 8, 0, 0));
            eq.push_back(mk_e(0, 0, 1, 0, 0, (i < 7) ? i : 7, 0));
        end
        // Back-to-back taken branches: flush windows of 3 cycles each.
        for (int i = 0; i < 9; i++) begin
            sq.push_back(mk_s(0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
            eq.push_back(mk_e(1, 1, 0, 1, (i % 3 == 0) ? 0 : 2, 7, (i < 7) ? i : 7));
        end
        sq.push_back(idle()); eq.push_back(mk_e(1, 1, 0, 0, 0, 7, 7));
        sq.push_back(idle()); eq.push_back(mk_e(1, 1, 0, 0, 0, 7, 7));
        for (int i = 0; i < sq.size(); i++) begin
            drive(1'b0, sq[i], eq[i]);
            @(negedge Clk);
            e = sb.pop_front();
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("FAIL saturation[%0d]: got %b want %b (pcw ifw bub fl st sc fc)",
                         i, obs, e);
            end
        end
    endtask

    initial begin
        Reset         = 1'b1;
        IFIDrs        = '0;
        IFIDrt        = '0;
        IFIDUsesRt    = 1'b0;
        IDBranch      = 1'b0;
        PCSrc         = 1'b0;
        IDEXMemRead   = 1'b0;
        IDEXRegWrite  = 1'b0;
        IDEXWriteReg  = '0;
        EXMEMMemRead  = 1'b0;
        EXMEMWriteReg = '0;
        test_reset();
        test_load_use();
        test_no_hazard();
        test_branch_after_load();
        test_taken_branch();
        test_stall_then_branch();
        test_reset_mid_seq();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
